// File: rtl/present_ti_pkg.sv
// PRESENT 3-share TI S-box layer: shared types and constants.
// Reference S-box is for checking models only.
package present_ti_pkg;

   localparam int DEF_NIBBLES = 16;
   localparam int DEF_STATE_W = 4 * DEF_NIBBLES;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

   function automatic logic [3:0] present_sbox(input logic [3:0] x);
      logic [3:0] y;
      y = 4'h0;
      unique case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/ti_nibble_shreg.sv
// One share register: parallel load, or shift right by one
// nibble with a new nibble inserted at the top.
module ti_nibble_shreg #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   input  logic [3:0]   ins,
   output logic [W-1:0] q
);

   // Load wins over shift; reset clears the share.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {ins, q[W-1:4]};
      end
   end

endmodule

// File: rtl/present_ti_sbox_layer_seq.sv
// Nibble-serial sequencer around an external 3-share TI S-box.
// Shares stay separate end to end; none are ever recombined.
module present_ti_sbox_layer_seq
   import present_ti_pkg::*;
#(
   parameter int NIBBLES = present_ti_pkg::DEF_NIBBLES,
   parameter int STATE_W = 4 * NIBBLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] st_in1,
   input  logic [STATE_W-1:0] st_in2,
   input  logic [STATE_W-1:0] st_in3,
   input  logic [STATE_W-1:0] rk_in1,
   input  logic [STATE_W-1:0] rk_in2,
   input  logic [STATE_W-1:0] rk_in3,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] st_out1,
   output logic [STATE_W-1:0] st_out2,
   output logic [STATE_W-1:0] st_out3,
   output logic [3:0]         sbox_in1,
   output logic [3:0]         sbox_in2,
   output logic [3:0]         sbox_in3,
   output logic               sbox_en,
   input  logic [3:0]         sbox_share1,
   input  logic [3:0]         sbox_share2,
   input  logic [3:0]         sbox_share3
);

   localparam int CW = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   seq_state_t state_q;
   seq_state_t state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   logic load;
   logic feed;
   logic cap;

   logic [STATE_W-1:0] ld_val  [3];
   logic [STATE_W-1:0] in_q    [3];
   logic [STATE_W-1:0] out_q   [3];
   logic [3:0]         cap_nib [3];

   // Next-state and counter logic for the IDLE/FEED/DRAIN walk.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FEED;
               cnt_d   = '0;
            end
         end
         FEED: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sbox_en <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy    <= (state_d != IDLE);
         sbox_en <= (state_d == FEED);
         done    <= (state_q == DRAIN);
      end
   end

   // Core output lags its input by one cycle, so the first
   // FEED edge has nothing valid to capture yet.
   assign load = (state_q == IDLE) && start;
   assign feed = (state_q == FEED);
   assign cap  = (feed && (cnt_q != '0)) || (state_q == DRAIN);

   assign ld_val[0] = st_in1 ^ rk_in1;
   assign ld_val[1] = st_in2 ^ rk_in2;
   assign ld_val[2] = st_in3 ^ rk_in3;

   assign cap_nib[0] = sbox_share1;
   assign cap_nib[1] = sbox_share2;
   assign cap_nib[2] = sbox_share3;

   for (genvar i = 0; i < 3; i++) begin : g_share
      ti_nibble_shreg #(
         .W(STATE_W)
      ) u_in (
         .clk  (clk),
         .rst  (rst),
         .load (load),
         .shift(feed),
         .d    (ld_val[i]),
         .ins  (4'h0),
         .q    (in_q[i])
      );

      ti_nibble_shreg #(
         .W(STATE_W)
      ) u_out (
         .clk  (clk),
         .rst  (rst),
         .load (1'b0),
         .shift(cap),
         .d    ({STATE_W{1'b0}}),
         .ins  (cap_nib[i]),
         .q    (out_q[i])
      );
   end

   assign sbox_in1 = in_q[0][3:0];
   assign sbox_in2 = in_q[1][3:0];
   assign sbox_in3 = in_q[2][3:0];

   assign st_out1 = out_q[0];
   assign st_out2 = out_q[1];
   assign st_out3 = out_q[2];

endmodule

// File: tb/tb_present_ti_sbox_layer_seq.sv
// Bench for the TI S-box layer sequencer with a behavioural
// 3-share core and a scoreboard-driven monitor.
module tb_present_ti_sbox_layer_seq;
   import present_ti_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] st_in1, st_in2, st_in3;
   logic [63:0] rk_in1, rk_in2, rk_in3;
   logic        busy, done, sbox_en;
   logic [63:0] st_out1, st_out2, st_out3;
   logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
   logic [3:0]  sbox_share1, sbox_share2, sbox_share3;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] i1, i2, i3;
      logic [63:0] e1, e2, e3;
      logic [63:0] rec;
   } txn_t;

   txn_t q[$];

   present_ti_sbox_layer_seq dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .st_in1     (st_in1),
      .st_in2     (st_in2),
      .st_in3     (st_in3),
      .rk_in1     (rk_in1),
      .rk_in2     (rk_in2),
      .rk_in3     (rk_in3),
      .busy       (busy),
      .done       (done),
      .st_out1    (st_out1),
      .st_out2    (st_out2),
      .st_out3    (st_out3),
      .sbox_in1   (sbox_in1),
      .sbox_in2   (sbox_in2),
      .sbox_in3   (sbox_in3),
      .sbox_en    (sbox_en),
      .sbox_share1(sbox_share1),
      .sbox_share2(sbox_share2),
      .sbox_share3(sbox_share3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Core model: one register stage, arbitrary contents until first enable.
   logic [3:0] c1 = 4'h9;
   logic [3:0] c2 = 4'h3;
   logic [3:0] c3 = 4'hE;

   always @(posedge clk) begin
      if (sbox_en) begin
         c1 <= present_sbox(sbox_in1 ^ sbox_in2 ^ sbox_in3)
               ^ sbox_in1 ^ sbox_in2;
         c2 <= sbox_in2 ^ sbox_in3;
         c3 <= sbox_in1 ^ sbox_in3;
      end
   end

   assign sbox_share1 = c1;
   assign sbox_share2 = c2;
   assign sbox_share3 = c3;

   function automatic logic [63:0] exp_share(input int s,
      input logic [63:0] a1, input logic [63:0] a2,
      input logic [63:0] a3);
      logic [63:0] r;
      logic [3:0]  x1, x2, x3;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         x1 = a1[4*k +: 4];
         x2 = a2[4*k +: 4];
         x3 = a3[4*k +: 4];
         if (s == 1)
            r[4*k +: 4] = present_sbox(x1 ^ x2 ^ x3) ^ x1 ^ x2;
         else if (s == 2)
            r[4*k +: 4] = x2 ^ x3;
         else
            r[4*k +: 4] = x1 ^ x3;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: pops a transaction when busy rises, checks every fed
   // nibble, and checks results, latency and stability at done.
   txn_t        cur;
   logic        active    = 1'b0;
   logic        have_last = 1'b0;
   logic        busy_p    = 1'b0;
   logic [63:0] l1, l2, l3;
   int          idx, en_cnt, bsy_cnt, rise_cyc;

   always @(negedge clk) begin
      if (rst) begin
         active    = 1'b0;
         have_last = 1'b0;
      end else begin
         if (busy && !busy_p) begin
            if (have_last) begin
               chk("hold_at_start1", st_out1, l1);
               chk("hold_at_start2", st_out2, l2);
               chk("hold_at_start3", st_out3, l3);
            end
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_start: busy rose, queue empty");
            end else begin
               cur    = q.pop_front();
               active = 1'b1;
            end
            idx      = 0;
            en_cnt   = 0;
            bsy_cnt  = 0;
            rise_cyc = cyc;
         end
         if (busy) bsy_cnt++;
         if (sbox_en) begin
            en_cnt++;
            if (active && idx < 16) begin
               chk("sbox_in1", {60'h0, sbox_in1}, (cur.i1 >> (4*idx)) & 64'hF);
               chk("sbox_in2", {60'h0, sbox_in2}, (cur.i2 >> (4*idx)) & 64'hF);
               chk("sbox_in3", {60'h0, sbox_in3}, (cur.i3 >> (4*idx)) & 64'hF);
            end
            idx++;
         end
         if (done) begin
            if (!active) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got 1 want 0");
            end else begin
               chk("st_out1", st_out1, cur.e1);
               chk("st_out2", st_out2, cur.e2);
               chk("st_out3", st_out3, cur.e3);
               chk("recombined", st_out1 ^ st_out2 ^ st_out3, cur.rec);
               chk("done_latency", 64'(cyc - rise_cyc + 1), 64'd18);
               chk("en_cycles", 64'(en_cnt), 64'd16);
               chk("busy_cycles", 64'(bsy_cnt), 64'd17);
               l1 = cur.e1;
               l2 = cur.e2;
               l3 = cur.e3;
               have_last = 1'b1;
            end
            active = 1'b0;
         end
         if (!busy && busy_p && !done) active = 1'b0;
         if (!busy && !done && have_last) begin
            chk("hold_idle1", st_out1, l1);
            chk("hold_idle2", st_out2, l2);
            chk("hold_idle3", st_out3, l3);
         end
      end
      busy_p = busy;
   end

   task automatic issue(input logic [63:0] s1, input logic [63:0] s2,
      input logic [63:0] s3, input logic [63:0] k1,
      input logic [63:0] k2, input logic [63:0] k3,
      input logic [63:0] rec);
      txn_t t;
      st_in1 = s1; st_in2 = s2; st_in3 = s3;
      rk_in1 = k1; rk_in2 = k2; rk_in3 = k3;
      t.i1  = s1 ^ k1;
      t.i2  = s2 ^ k2;
      t.i3  = s3 ^ k3;
      t.e1  = exp_share(1, t.i1, t.i2, t.i3);
      t.e2  = exp_share(2, t.i1, t.i2, t.i3);
      t.e3  = exp_share(3, t.i1, t.i2, t.i3);
      t.rec = rec;
      q.push_back(t);
      start = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 40);
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s: done timeout after %0d cycles want 18", name, n);
      end
   endtask

   task automatic run1(input string name, input logic [63:0] s1,
      input logic [63:0] s2, input logic [63:0] s3,
      input logic [63:0] k1, input logic [63:0] k2,
      input logic [63:0] k3, input logic [63:0] rec);
      issue(s1, s2, s3, k1, k2, k3, rec);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(name);
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
   localparam logic [63:0] Y0 = 64'hC56B90AD3EF84712;
   localparam logic [63:0] PF = 64'hFEDCBA9876543210;
   localparam logic [63:0] YF = 64'h21748FE3DA09B65C;
   localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

   logic [63:0] r1, r2;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      st_in1 = '0; st_in2 = '0; st_in3 = '0;
      rk_in1 = '0; rk_in2 = '0; rk_in3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_en", {63'h0, sbox_en}, 64'h0);
      chk("rst_in1", {60'h0, sbox_in1}, 64'h0);
      chk("rst_in2", {60'h0, sbox_in2}, 64'h0);
      chk("rst_in3", {60'h0, sbox_in3}, 64'h0);
      chk("rst_out1", st_out1, 64'h0);
      chk("rst_out2", st_out2, 64'h0);
      chk("rst_out3", st_out3, 64'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      r1 = rnd64(); r2 = rnd64();
      run1("zero", r1, r2, r1 ^ r2, 0, 0, 0, 64'hCCCCCCCCCCCCCCCC);

      r1 = rnd64(); r2 = rnd64();
      run1("ramp", r1, r2, P0 ^ r1 ^ r2, 0, 0, 0, Y0);

      r1 = rnd64(); r2 = rnd64();
      run1("key_ones", 0, 0, 0, r1, r2, ONES ^ r1 ^ r2,
           64'h2222222222222222);

      r1 = rnd64(); r2 = rnd64();
      issue(r2, P0 ^ r1 ^ r2, r1, 0, 0, 0, Y0);
      wait_done("held_a");
      r1 = rnd64(); r2 = rnd64();
      issue(0, 0, 0, r1, ONES ^ r1 ^ r2, r2, 64'h2222222222222222);
      wait_done("held_b");
      r1 = rnd64(); r2 = rnd64();
      issue(r1 ^ r2, r1, r2, 0, 0, 0, 64'hCCCCCCCCCCCCCCCC);
      wait_done("held_c");
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      r1 = rnd64(); r2 = rnd64();
      issue(r1, r2, P0 ^ r1 ^ r2, 0, 0, 0, Y0);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", {63'h0, busy}, 64'h0);
      chk("abort_done", {63'h0, done}, 64'h0);
      chk("abort_en", {63'h0, sbox_en}, 64'h0);
      chk("abort_in", {52'h0, sbox_in1, sbox_in2, sbox_in3}, 64'h0);
      chk("abort_out1", st_out1, 64'h0);
      chk("abort_out2", st_out2, 64'h0);
      chk("abort_out3", st_out3, 64'h0);
      chk("abort_queue", 64'(q.size()), 64'h0);
      repeat (25) @(posedge clk);
      #1;

      r1 = rnd64(); r2 = rnd64();
      run1("after_abort", r1, P0 ^ r1 ^ r2, r2, 0, 0, 0, Y0);

      run1("share1_only", P0, 0, 0, 0, 0, 0, Y0);
      run1("share2_toggled", P0, ONES, 0, 0, 0, 0, YF);
      run1("share3_toggled", P0, 0, ONES, 0, 0, 0, YF);
      run1("key1_toggled", P0, 0, 0, ONES, 0, 0, YF);

      chk("queue_drained", 64'(q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
